dcache_wb_assoc: RTL
====================

Name: dcache_wb_assoc

Overview:
- Parametrised write-back, write-allocate, set-associative data cache for the MEM stage of the pipelined core.
- Successor to the fixed 4 KiB 2-way data cache. Adds parametrised geometry, dirty tracking with line write-back, word-burst refill, byte-enabled stores and a complete miss FSM.
- Sits between the pipeline MEM stage and the single-word backing-memory port.

Parameters:
- WAYS, 2, associativity; legal values 1 or 2. With 1, LRU logic is absent.
- SETS, 128, number of sets; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.
- Derived: OFF_W=log2(LINE_WORDS), IDX_W=log2(SETS), TAG_W=30-IDX_W-OFF_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- memReadM  in  1  load request.
- memWriteM  in  1  store request.
- addrM  in  32  byte address; bits [1:0] ignored.
- writeDataM  in  32  store data.
- byteEnM  in  4  store byte lanes.
- readDataM  out  32  load data; valid when memReadM=1 and stallM=0.
- stallM  out  1  freezes the pipeline; the request is held stable while it is high.
- mem_read  out  1  backing read request.
- mem_write  out  1  backing write request.
- mem_addr  out  32  word-aligned backing address.
- mem_wdata  out  32  write-back data.
- mem_rdata  in  32  refill data.
- mem_ready  in  1  one-cycle acknowledge of the current word.

Behaviour:
- Address split: offset=addrM[OFF_W+1:2], index=addrM[OFF_W+IDX_W+1:OFF_W+2], tag=addrM[31:OFF_W+IDX_W+2].
- Per line: valid, dirty, tag, data. One LRU bit per set; LRU points at the victim way.
- Hit path, IDLE only:
  - hit = valid && tag match in any way.
  - Load hit: readDataM is combinational from the hit way the same cycle; stallM=0.
  - Store hit: the bytes selected by byteEnM are written at the clock edge, dirty is set, stallM=0.
  - Any hit sets LRU to the other way.
- stallM = (req && !hit && state==IDLE) || state!=IDLE, where req = memReadM || memWriteM.
- If memReadM and memWriteM are both high, the access is treated as a store.
- FSM states: IDLE, WRITEBACK, REFILL.
  - IDLE → WRITEBACK on a miss when the victim is valid and dirty. Victim is the invalid way first (way 0 first), otherwise the LRU way.
  - IDLE → REFILL on a miss with a clean or invalid victim.
  - WRITEBACK: mem_write=1, mem_addr={victim tag, index, beat, 2'b00}, mem_wdata=victim word[beat]. Beat advances on mem_ready. After the last beat: clear dirty, beat=0, go to REFILL.
  - REFILL: mem_read=1, mem_addr={tag, index, beat, 2'b00}. On mem_ready, mem_rdata is written to word[beat] of the victim. After the last beat: valid=1, tag updated, dirty=0, go to IDLE.
  - Back in IDLE the held request hits, the access completes, and stallM drops that cycle.
- Miss penalty: at least LINE_WORDS+1 cycles for a clean miss, at least 2*LINE_WORDS+1 for a dirty miss. Each wait cycle without mem_ready adds one cycle.
- mem_read and mem_write are never high together. Both are held until mem_ready. Both are 0 in IDLE.
- The beat counter is OFF_W bits and wraps to 0 after the last beat.
- mem_ready outside WRITEBACK/REFILL is ignored.
- Reset (reset=0 at a clock edge), including mid-burst:
  - state=IDLE, beat=0, all valid/dirty/LRU cleared; dirty data is discarded.
  - mem_read=0, mem_write=0, stallM=0 with no request; mem_addr=0, mem_wdata=0.
  - readDataM=0 when no hit.

Optional Feature:
- DCACHE_STATS_EN defined: adds outputs hit_cnt, miss_cnt, wb_cnt (32 bits each, saturating, cleared by reset).
  - hit_cnt increments on the completing cycle of an access that hit in IDLE without stalling.
  - miss_cnt increments on each IDLE→miss transition.
  - wb_cnt increments on each entry to WRITEBACK.
- Undefined: the ports and counters are absent; functional behaviour is identical.

Decomposition:
- Package dcache_pkg holds:
  - the state enum dcache_state_t;
  - the default geometry constants;
  - a function that merges byte-enabled store data into a word.
- Sub-module dcache_way_array (parameters SETS, LINE_WORDS, TAG_W) holds one way's tag/valid/dirty/data storage with combinational read and byte-masked write. It is instantiated WAYS times.

Test Plan:
- Cold load 0x0000_1004 with mem_ready after 2 wait cycles per beat → 4 reads at 0x1000..0x100C, stallM for 13 cycles, readDataM = the word returned for 0x1004.
- Store 0xDEADBEEF, byteEnM=4'b0011, to a resident line → same cycle stallM=0; subsequent load returns 0xXXXXBEEF, with the upper bytes unchanged.
- Dirty eviction: dirty lines at 0x0000_0000 (way 0) and 0x0000_0800 (way 1), then load 0x0000_1000 with the default geometry → LRU victim written back as 4 writes, then 4 reads; mem_read and mem_write are never high together.
- LRU ordering: fill both ways of set 0, touch way 0, miss into set 0 → way 1 is replaced; a later load of the way-0 address hits with stallM=0.
- reset=0 during beat 2 of REFILL → next cycle mem_read=0 and stallM=0 with no request; a reload of the same address misses again.
- WAYS=1, SETS=16, LINE_WORDS=8: conflicting addresses 0x000 and 0x200 alternate → every access misses, each with an 8-beat refill.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, default geometry and the byte-merge helper for the write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } dcache_state_t;

  localparam int unsigned DEF_WAYS       = 2;
  localparam int unsigned DEF_SETS       = 128;
  localparam int unsigned DEF_LINE_WORDS = 4;

  // Replace only the byte lanes selected by be.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_word[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: valid/dirty/tag per set plus line data, combinational read, byte-masked write.
module dcache_way_array
  import dcache_pkg::*;
#(
  parameter int unsigned SETS       = DEF_SETS,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned TAG_W      = 30 - $clog2(SETS) - $clog2(LINE_WORDS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(SETS)-1:0]       idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_off,
  output logic                          valid,
  output logic                          dirty,
  output logic [TAG_W-1:0]              tag,
  output logic [31:0]                   rdata,
  input  logic                          wr_en,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_off,
  input  logic [31:0]                   wr_data,
  input  logic [3:0]                    wr_be,
  input  logic                          meta_we,
  input  logic                          meta_dirty,
  input  logic [TAG_W-1:0]              meta_tag
);

  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned ADDR_W = IDX_W + OFF_W;

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS*LINE_WORDS];
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  assign rd_addr = {idx, rd_off};
  assign wr_addr = {idx, wr_off};

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign rdata = data_q[rd_addr];

  // Line status; a metadata write always leaves the line valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= meta_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (meta_we) tag_q[idx] <= meta_tag;
    if (wr_en)   data_q[wr_addr] <= merge_bytes(data_q[wr_addr], wr_data, wr_be);
  end

endmodule

// File: rtl/dcache_wb_assoc.sv
// Write-back, write-allocate set-associative data cache with burst refill and dirty write-back.
// Optional hit/miss/write-back counters are enabled by defining DCACHE_STATS_EN.
module dcache_wb_assoc
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS       = DEF_WAYS,
  parameter int unsigned SETS       = DEF_SETS,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [31:0] addrM,
  input  logic [31:0] writeDataM,
  input  logic [3:0]  byteEnM,
  output logic [31:0] readDataM,
  output logic        stallM,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] wb_cnt
`endif
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  logic             req;
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_addr;

  assign req         = memReadM | memWriteM;
  assign off         = addrM[OFF_W+1:2];
  assign idx         = addrM[OFF_W+IDX_W+1:OFF_W+2];
  assign tag         = addrM[31:OFF_W+IDX_W+2];
  assign unused_addr = ^addrM[1:0];

  dcache_state_t    state_q, state_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic             victim_q, victim_d;

  logic [WAYS-1:0]  way_valid, way_dirty, way_hit;
  logic [TAG_W-1:0] way_tag   [WAYS];
  logic [31:0]      way_rdata [WAYS];
  logic [OFF_W-1:0] rd_off;

  logic             wr_en, wr_way, meta_we, meta_dirty;
  logic [OFF_W-1:0] wr_off;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;
  logic [TAG_W-1:0] meta_tag;

  // Burst beats read the victim line; otherwise the request offset is read.
  assign rd_off = (state_q == ST_IDLE) ? off : beat_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way_array #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W)
    ) u_way (
      .clk        (clk),
      .reset      (reset),
      .idx        (idx),
      .rd_off     (rd_off),
      .valid      (way_valid[w]),
      .dirty      (way_dirty[w]),
      .tag        (way_tag[w]),
      .rdata      (way_rdata[w]),
      .wr_en      (wr_en && (wr_way == 1'(w))),
      .wr_off     (wr_off),
      .wr_data    (wr_data),
      .wr_be      (wr_be),
      .meta_we    (meta_we && (wr_way == 1'(w))),
      .meta_dirty (meta_dirty),
      .meta_tag   (meta_tag)
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == tag);
  end

  logic             hit, hit_way, victim_sel, vic_sel_valid, vic_sel_dirty;
  logic [TAG_W-1:0] vic_tag;
  logic [31:0]      vic_rdata, hit_rdata;

  assign hit = |way_hit;

  if (WAYS == 2) begin : g_two
    logic [SETS-1:0] lru_q;

    assign hit_way       = way_hit[1];
    assign victim_sel    = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[idx]);
    assign vic_sel_valid = victim_sel ? way_valid[1] : way_valid[0];
    assign vic_sel_dirty = victim_sel ? way_dirty[1] : way_dirty[0];
    assign vic_tag       = victim_q ? way_tag[1] : way_tag[0];
    assign vic_rdata     = victim_q ? way_rdata[1] : way_rdata[0];
    assign hit_rdata     = hit_way ? way_rdata[1] : way_rdata[0];

    // LRU names the victim: after a hit it points at the other way.
    always_ff @(posedge clk) begin
      if (!reset) begin
        lru_q <= '0;
      end else if (state_q == ST_IDLE && req && hit) begin
        lru_q[idx] <= ~hit_way;
      end
    end
  end else begin : g_one
    assign hit_way       = 1'b0;
    assign victim_sel    = 1'b0;
    assign vic_sel_valid = way_valid[0];
    assign vic_sel_dirty = way_dirty[0];
    assign vic_tag       = way_tag[0];
    assign vic_rdata     = way_rdata[0];
    assign hit_rdata     = way_rdata[0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
    end
  end

  // Next state, array write controls and memory-port outputs.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    victim_d   = victim_q;
    stallM     = 1'b0;
    readDataM  = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_en      = 1'b0;
    wr_way     = hit_way;
    wr_off     = off;
    wr_data    = writeDataM;
    wr_be      = byteEnM;
    meta_we    = 1'b0;
    meta_dirty = 1'b0;
    meta_tag   = tag;

    unique case (state_q)
      ST_IDLE: begin
        if (hit) readDataM = hit_rdata;
        if (req && hit && memWriteM) begin
          wr_en      = 1'b1;
          meta_we    = 1'b1;
          meta_dirty = 1'b1;
        end else if (req && !hit) begin
          stallM   = 1'b1;
          victim_d = victim_sel;
          state_d  = (vic_sel_valid && vic_sel_dirty) ? ST_WRITEBACK : ST_REFILL;
        end
      end
      ST_WRITEBACK: begin
        stallM    = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {vic_tag, idx, beat_q, 2'b00};
        mem_wdata = vic_rdata;
        if (mem_ready) begin
          beat_d = beat_q + OFF_W'(1);
          if (beat_q == LAST_BEAT) begin
            wr_way   = victim_q;
            meta_we  = 1'b1;
            meta_tag = vic_tag;
            state_d  = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        stallM   = 1'b1;
        mem_read = 1'b1;
        mem_addr = {tag, idx, beat_q, 2'b00};
        if (mem_ready) begin
          wr_en   = 1'b1;
          wr_way  = victim_q;
          wr_off  = beat_q;
          wr_data = mem_rdata;
          wr_be   = 4'hF;
          beat_d  = beat_q + OFF_W'(1);
          if (beat_q == LAST_BEAT) begin
            meta_we = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (state_q == ST_IDLE && req && hit && hit_cnt != '1)   hit_cnt  <= hit_cnt + 32'd1;
      if (state_q == ST_IDLE && req && !hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      if (state_q == ST_IDLE && state_d == ST_WRITEBACK && wb_cnt != '1) wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule
